mean_update: RTL
================

# mean_update

Sequential centroid-recompute block on the return path of the k-means loop. It latches the per-cluster channel sums (`accumolator`) and pixel counts (`counters`) that `cluster_engine` produces at the end of a pass. It then divides each sum by its count with one shared-schedule restoring divider per colour channel, and publishes the new 16-entry mean vector in the same packing `cluster_engine` takes on `meanIn`. The block also reports whether any mean moved, which drives the convergence decision.

## Interface
- `K`, 16, number of clusters
- `CH_W`, 8, bits per colour channel (3 channels per pixel/mean)
- `ACC_W`, 32, bits per channel accumulator
- `CNT_W`, 24, bits per cluster pixel counter

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begin a recompute (accepted only in IDLE)
- `accumolator`  in  K*3*ACC_W  sum for cluster i, channel c at `[ACC_W*(3*i+c) +: ACC_W]`
- `counters`  in  K*CNT_W  pixel count for cluster i at `[CNT_W*i +: CNT_W]`
- `meanIn`  in  K*3*CH_W  current means; cluster i at `[24*i +: 24]`, channel c at `[24*i+8*c +: 8]`
- `enabled`  in  K  cluster i participates when bit i = 1
- `meanOut`  out  K*3*CH_W  recomputed means, same packing as `meanIn`
- `busy`  out  1  recompute in progress
- `done`  out  1  one-cycle pulse: `meanOut`/`changed` just committed
- `changed`  out  1  at least one committed mean differs from its latched old value

## Operation
- States: IDLE, LOAD, DIV, STORE, DONE.
- IDLE:
  - `start`=1 latches `accumolator`, `counters`, `meanIn`, `enabled` into snapshot registers.
  - Sets cluster index i=0 and moves to LOAD.
  - Inputs may change freely after the latch edge.
- LOAD: loads three dividers with the cluster-i channel sums (dividends), divisor = count i, remainders = 0, bit counter = ACC_W-1. Next state: DIV.
- DIV:
  - Each cycle, each divider performs one restoring step, MSB first.
  - Remainder register is CNT_W+1 bits; quotient register is ACC_W bits.
  - After ACC_W steps, next state: STORE.
- STORE, per channel c of cluster i:
  - Keep the latched old mean byte when `enabled[i]`=0 or count i = 0.
  - Otherwise use the floor quotient, saturated to 255 when quotient > 255.
  - Write the result into the shadow mean register.
  - OR the "differs from old" flag into a sticky change bit.
  - If i = K-1, go to DONE; else i++ and go to LOAD.
- Divisor-zero and disabled clusters still run the full LOAD/DIV/STORE slot, so latency is fixed.
- DONE:
  - Copy the shadow register to `meanOut` and the sticky bit to `changed`.
  - Assert `done`, clear the sticky bit, return to IDLE.
- `start` outside IDLE is ignored; no queueing.
- `reset` low at any time:
  - State returns to IDLE; all outputs and the shadow/snapshot registers clear to 0.
  - A pass in progress is abandoned with no partial commit.

## Timing
- Reset values: `meanOut`=0, `busy`=0, `done`=0, `changed`=0.
- `start` is sampled at edge T0.
- `busy` is 1 from T0+ through the DONE cycle inclusive; it is 0 again after edge T0+K*(ACC_W+2)+1.
- Per cluster slot: ACC_W+2 cycles (1 LOAD + ACC_W DIV + 1 STORE).
- `done` is high for exactly one cycle, from edge T0+K*(ACC_W+2) to the next edge; with defaults, 544 cycles after T0.
- `meanOut` and `changed` change only at the edge entering the `done`-high cycle, and hold until the next commit or reset.
- A `start` high in the same cycle as `done` is ignored, because the FSM is not yet in IDLE. The earliest new start is the cycle after `done`.

## Test plan
- Cluster 0: sums {R=160, G=320, B=480}, count 10, all enabled, other counts 0 with `meanIn` = 0 -> `meanOut[23:0]` = {B=48, G=32, R=16}, `changed`=1, `done` pulses exactly 544 cycles after `start`, `busy` high for 545 cycles.
- Cluster 5: count 0, `meanIn` cluster 5 = 0x808080 -> `meanOut` cluster 5 = 0x808080. If all clusters have count 0 -> `meanOut` = `meanIn` and `changed`=0.
- Arithmetic: sum 10 / count 3 -> 3 (floor); sum 1000 / count 3 -> 255 (saturate); sum 0xFFFFFFFF / count 0xFFFFFF -> 255; sum 7 / count 8 -> 0.
- `enabled` = 0xFFFE with cluster 0 sums/count that would yield 16, `meanIn` cluster 0 = 0x2A2A2A -> cluster 0 stays 0x2A2A2A; other clusters are computed normally.
- `start` re-pulsed at cycle 100 of a pass -> no restart, `done` still at 544. Inputs changed at cycle 1 -> results reflect the T0 snapshot.
- `reset` low at cycle 300 -> immediately `busy`=0, `meanOut`=0, no `done`. Release, then `start` -> a full 544-cycle pass with correct results.

Source files
------------

// File: rtl/mean_update.sv
// Centroid recompute for the k-means loop: snapshots per-cluster sums/counts, divides each
// channel sum by its count with three restoring dividers sharing one schedule, and commits new means.
module mean_update #(
  parameter int K     = 16,
  parameter int CH_W  = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [K*3*ACC_W-1:0]   accumolator,
  input  logic [K*CNT_W-1:0]     counters,
  input  logic [K*3*CH_W-1:0]    meanIn,
  input  logic [K-1:0]           enabled,
  output logic [K*3*CH_W-1:0]    meanOut,
  output logic                   busy,
  output logic                   done,
  output logic                   changed
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int BW = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [ACC_W-1:0] QMAX = ACC_W'((1 << CH_W) - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, DONE} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx;
  logic [BW-1:0]          bitcnt;
  logic [K*3*ACC_W-1:0]   acc_s;
  logic [K*CNT_W-1:0]     cnt_s;
  logic [K*3*CH_W-1:0]    old_s;
  logic [K-1:0]           en_s;
  logic [K*3*CH_W-1:0]    shadow;
  logic                   sticky;
  logic [CNT_W-1:0]       dvs;
  logic [ACC_W-1:0]       quo     [3];
  logic [CNT_W:0]         rem     [3];
  logic [ACC_W-1:0]       quo_nxt [3];
  logic [CNT_W:0]         rem_nxt [3];
  logic [CNT_W+1:0]       trial   [3];
  logic                   ge      [3];
  logic [K*3*CH_W-1:0]    shadow_nxt;
  logic                   diff;
  logic                   keep;
  logic [CH_W-1:0]        old_b, new_b;

  function automatic logic [CH_W-1:0] sat_q(input logic [ACC_W-1:0] q);
    return (q > QMAX) ? {CH_W{1'b1}} : q[CH_W-1:0];
  endfunction

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = DIV;
      DIV:     if (bitcnt == '0) state_nxt = STORE;
      STORE:   state_nxt = (idx == IW'(K-1)) ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step per channel: shift the next dividend bit into the remainder
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      trial[c]   = {rem[c], quo[c][ACC_W-1]};
      ge[c]      = (trial[c] >= {2'b00, dvs});
      rem_nxt[c] = ge[c] ? (CNT_W+1)'(trial[c] - {2'b00, dvs}) : (CNT_W+1)'(trial[c]);
      quo_nxt[c] = {quo[c][ACC_W-2:0], ge[c]};
    end
  end

  // Store stage: pick quotient or old byte, merge into shadow, flag any change
  always_comb begin
    shadow_nxt = shadow;
    diff       = 1'b0;
    old_b      = '0;
    new_b      = '0;
    keep       = !en_s[idx] || (cnt_s[idx*CNT_W +: CNT_W] == '0);
    for (int c = 0; c < 3; c++) begin
      old_b = old_s[(3*idx+c)*CH_W +: CH_W];
      new_b = keep ? old_b : sat_q(quo[c]);
      shadow_nxt[(3*idx+c)*CH_W +: CH_W] = new_b;
      diff = diff | (new_b != old_b);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      bitcnt  <= '0;
      acc_s   <= '0;
      cnt_s   <= '0;
      old_s   <= '0;
      en_s    <= '0;
      shadow  <= '0;
      sticky  <= 1'b0;
      dvs     <= '0;
      meanOut <= '0;
      changed <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        quo[c] <= '0;
        rem[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          acc_s <= accumolator;
          cnt_s <= counters;
          old_s <= meanIn;
          en_s  <= enabled;
          idx   <= '0;
        end
        LOAD: begin
          dvs    <= cnt_s[idx*CNT_W +: CNT_W];
          bitcnt <= BW'(ACC_W-1);
          for (int c = 0; c < 3; c++) begin
            quo[c] <= acc_s[(3*idx+c)*ACC_W +: ACC_W];
            rem[c] <= '0;
          end
        end
        DIV: begin
          bitcnt <= bitcnt - 1'b1;
          for (int c = 0; c < 3; c++) begin
            quo[c] <= quo_nxt[c];
            rem[c] <= rem_nxt[c];
          end
        end
        STORE: begin
          shadow <= shadow_nxt;
          sticky <= sticky | diff;
          // Commit on the last slot so outputs change at the edge entering DONE
          if (idx == IW'(K-1)) begin
            meanOut <= shadow_nxt;
            changed <= sticky | diff;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: sticky <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
